// File: rtl/mem_dump_pkg.sv
// Shared types and helpers for the memory dump reader.
// Block geometry follows MAIN_MEM_BLOCK_OFFSET_WIDTH (defaults to 3 when not set globally).
`ifndef MAIN_MEM_BLOCK_OFFSET_WIDTH
`define MAIN_MEM_BLOCK_OFFSET_WIDTH 3
`endif

package mem_dump_pkg;
    localparam int ADDR_W    = 32;
    localparam int BLK_OFF_W = `MAIN_MEM_BLOCK_OFFSET_WIDTH;

    typedef logic [ADDR_W-1:0]               addr_t;
    typedef logic [ADDR_W-BLK_OFF_W-1:0]     main_mem_block_addr_t;
    typedef logic [BLK_OFF_W-1:0]            main_mem_block_offset_t;
    typedef logic [8*(2**BLK_OFF_W)-1:0]     block_data_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        EMIT,
        DONE
    } mem_dump_state_t;

    function automatic int words_per_block(input int off_w);
        return 2 ** (off_w - 2);
    endfunction
endpackage

// File: rtl/mem_dump_word_sel.sv
// Combinational extractor: picks the 32-bit word at a word index out of a memory block.
module mem_dump_word_sel #(
    parameter int BLOCK_OFFSET_WIDTH = 3,
    parameter int IDX_W              = 1
) (
    input  logic [8*(2**BLOCK_OFFSET_WIDTH)-1:0] i_block_data,
    input  logic [IDX_W-1:0]                     i_word_idx,
    output logic [31:0]                          o_word
);
    generate
        if (BLOCK_OFFSET_WIDTH > 2) begin : g_multi
            // Word i occupies bytes 4i..4i+3, i.e. bits starting at 32*i.
            assign o_word = i_block_data[{i_word_idx, 5'b00000} +: 32];
        end else begin : g_single
            logic w_unused_idx;
            assign w_unused_idx = ^i_word_idx;
            assign o_word       = i_block_data;
        end
    endgenerate
endmodule

// File: rtl/mem_dump_unit.sv
// Walks a word-aligned byte range, fetching one memory block at a time and streaming tagged words.
// Optional MEM_DUMP_CHECKSUM_EN adds a running 32-bit sum of every accepted word.
module mem_dump_unit
    import mem_dump_pkg::*;
#(
    parameter int ADDR_WIDTH         = 32,
    parameter int BLOCK_OFFSET_WIDTH = BLK_OFF_W
) (
    input  logic                                   clk,
    input  logic                                   rst_aL,
    input  logic                                   start,
    input  logic [ADDR_WIDTH-1:0]                  start_addr,
    input  logic [ADDR_WIDTH-1:0]                  end_addr,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   mem_req_valid,
    input  logic                                   mem_req_ready,
    output logic [ADDR_WIDTH-BLOCK_OFFSET_WIDTH-1:0] mem_req_block_addr,
    input  logic                                   mem_resp_valid,
    input  logic [8*(2**BLOCK_OFFSET_WIDTH)-1:0]   mem_resp_block_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [ADDR_WIDTH-1:0]                  out_addr,
    output logic [31:0]                            out_data,
`ifdef MEM_DUMP_CHECKSUM_EN
    output logic [31:0]                            checksum,
`endif
    output logic                                   out_last
);
    localparam int BLK_W = 8 * (2 ** BLOCK_OFFSET_WIDTH);
    localparam int WPB   = words_per_block(BLOCK_OFFSET_WIDTH);
    localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;

    mem_dump_state_t         r_state;
    mem_dump_state_t         w_next_state;
    logic [ADDR_WIDTH-1:0]   r_cur_addr;
    logic [ADDR_WIDTH-1:0]   r_end_q;
    logic [BLK_W-1:0]        r_buf;
    logic [ADDR_WIDTH-1:0]   w_start_al;
    logic [ADDR_WIDTH-1:0]   w_end_al;
    logic [ADDR_WIDTH-1:0]   w_next_addr;
    logic [IDX_W-1:0]        w_word_idx;
    logic [31:0]             w_word;
    logic                    w_last;
    logic                    w_block_wrap;
    logic                    w_out_hs;

    assign w_start_al  = {start_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_end_al    = {end_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_next_addr = r_cur_addr + ADDR_WIDTH'(4);
    assign w_last      = (w_next_addr >= r_end_q);
    assign w_out_hs    = (r_state == EMIT) && out_ready;

    generate
        if (BLOCK_OFFSET_WIDTH > 2) begin : g_idx
            assign w_word_idx   = r_cur_addr[BLOCK_OFFSET_WIDTH-1:2];
            // Offset bits rolling over to zero means the next word lives in a new block.
            assign w_block_wrap = (w_next_addr[BLOCK_OFFSET_WIDTH-1:2] == '0);
        end else begin : g_idx1
            assign w_word_idx   = 1'b0;
            assign w_block_wrap = 1'b1;
        end
    endgenerate

    mem_dump_word_sel #(
        .BLOCK_OFFSET_WIDTH (BLOCK_OFFSET_WIDTH),
        .IDX_W              (IDX_W)
    ) u_word_sel (
        .i_block_data (r_buf),
        .i_word_idx   (w_word_idx),
        .o_word       (w_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (w_start_al >= w_end_al) ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    w_next_state = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (w_last) begin
                        w_next_state = DONE;
                    end else if (w_block_wrap) begin
                        w_next_state = REQ;
                    end else begin
                        w_next_state = EMIT;
                    end
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy          = (r_state != IDLE);
        done          = (r_state == DONE);
        mem_req_valid = (r_state == REQ);
        out_valid     = (r_state == EMIT);
        out_last      = (r_state == EMIT) && w_last;
    end

    assign mem_req_block_addr = r_cur_addr[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH];
    assign out_addr           = r_cur_addr;
    assign out_data           = w_word;

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            r_cur_addr <= '0;
            r_end_q    <= '0;
            r_buf      <= '0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_cur_addr <= w_start_al;
                r_end_q    <= w_end_al;
            end
            if ((r_state == WAIT) && mem_resp_valid) begin
                r_buf <= mem_resp_block_data;
            end
            if (w_out_hs) begin
                r_cur_addr <= w_next_addr;
            end
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            r_checksum <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_checksum <= '0;
        end else if (w_out_hs) begin
            r_checksum <= r_checksum + w_word;
        end
    end

    assign checksum = r_checksum;
`endif
endmodule

// File: tb/tb_mem_dump_unit.sv
// Directed bench for mem_dump_unit with a range/memory model and a per-cycle compare process.
`timescale 1ns/1ps
module tb_mem_dump_unit;
    logic        clk = 1'b0;
    logic        rst_aL = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic [31:0] end_addr = '0;
    logic        busy, done;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [28:0] mem_req_block_addr;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_block_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_addr, out_data;
    logic        out_last;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    mem_dump_unit #(.ADDR_WIDTH(32), .BLOCK_OFFSET_WIDTH(3)) dut (
        .clk                 (clk),
        .rst_aL              (rst_aL),
        .start               (start),
        .start_addr          (start_addr),
        .end_addr            (end_addr),
        .busy                (busy),
        .done                (done),
        .mem_req_valid       (mem_req_valid),
        .mem_req_ready       (mem_req_ready),
        .mem_req_block_addr  (mem_req_block_addr),
        .mem_resp_valid      (mem_resp_valid),
        .mem_resp_block_data (mem_resp_block_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_addr            (out_addr),
        .out_data            (out_data),
`ifdef MEM_DUMP_CHECKSUM_EN
        .checksum            (checksum),
`endif
        .out_last            (out_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Memory image: explicit words where loaded, otherwise an address hash.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [63:0] block_of(input logic [28:0] b);
        return {mem_word({b, 3'b100}), mem_word({b, 3'b000})};
    endfunction

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [28:0] exp_blk[$];
    logic [31:0] exp_sum;
    int          exp_nblk;

    task automatic model_load(input logic [31:0] s, input logic [31:0] e);
        logic [31:0] a, ee;
        exp_addr.delete();
        exp_data.delete();
        exp_blk.delete();
        exp_sum = '0;
        a  = s & ~32'd3;
        ee = e & ~32'd3;
        while (a < ee) begin
            exp_addr.push_back(a);
            exp_data.push_back(mem_word(a));
            exp_sum = exp_sum + mem_word(a);
            if (exp_blk.size() == 0 || exp_blk[$] != a[31:3]) exp_blk.push_back(a[31:3]);
            a = a + 32'd4;
        end
        exp_nblk = exp_blk.size();
    endtask

    // Responder / sink stimulus state.
    int          resp_cnt = 0;
    int          resp_lat = 1;
    int          req_stall = 0;
    int          out_stall = 0;
    logic [28:0] resp_blk = '0;

    initial forever begin
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_resp_valid      = 1'b1;
                mem_resp_block_data = block_of(resp_blk);
            end
        end
        if (mem_req_valid && req_stall > 0) begin
            mem_req_ready = 1'b0;
            req_stall--;
        end else begin
            mem_req_ready = 1'b1;
        end
        if (out_valid && out_stall > 0) begin
            out_ready = 1'b0;
            out_stall--;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Per-cycle compare against the model.
    int          cyc = 0;
    int          done_cnt = 0, done_cyc = -1, last_hs_cyc = -1, req_cnt = 0, resp_cyc = -10;
    bit          chk_resp_lat = 1'b1;
    logic        prev_ov = 0, prev_or = 0, prev_ol = 0, prev_rv = 0, prev_rr = 0;
    logic [31:0] prev_oa = '0, prev_od = '0;
    logic [28:0] prev_ra = '0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic        got_last[$];

    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst_aL) begin
            chk("req_emit_exclusive", out_valid && mem_req_valid, 0);
            if (prev_ov && !prev_or) begin
                chk("out_hold_valid", out_valid, 1);
                chk("out_hold_addr", out_addr, prev_oa);
                chk("out_hold_data", out_data, prev_od);
                chk("out_hold_last", out_last, prev_ol);
            end
            if (prev_rv && !prev_rr) begin
                chk("req_hold_valid", mem_req_valid, 1);
                chk("req_hold_addr", mem_req_block_addr, prev_ra);
            end
            if (chk_resp_lat && resp_cyc == cyc - 1) chk("resp_to_out_latency", out_valid, 1);
            if (mem_resp_valid) resp_cyc = cyc;
            if (mem_req_valid && mem_req_ready) begin
                req_cnt++;
                chk("req_expected", exp_blk.size() != 0, 1);
                if (exp_blk.size() != 0) chk("req_block_addr", mem_req_block_addr, exp_blk.pop_front());
                resp_cnt = resp_lat;
                resp_blk = mem_req_block_addr;
            end
            if (out_valid && out_ready) begin
                chk("out_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) begin
                    chk("out_addr", out_addr, exp_addr[0]);
                    chk("out_data", out_data, exp_data[0]);
                    chk("out_last", out_last, exp_addr.size() == 1);
                    void'(exp_addr.pop_front());
                    void'(exp_data.pop_front());
                end
                got_addr.push_back(out_addr);
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_words_remaining", exp_addr.size(), 0);
                chk("done_busy", busy, 1);
`ifdef MEM_DUMP_CHECKSUM_EN
                chk("checksum", checksum, exp_sum);
`endif
            end
            prev_ov = out_valid;  prev_or = out_ready;  prev_ol = out_last;
            prev_oa = out_addr;   prev_od = out_data;
            prev_rv = mem_req_valid; prev_rr = mem_req_ready; prev_ra = mem_req_block_addr;
        end else begin
            prev_ov = 1'b0;
            prev_rv = 1'b0;
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_req_valid"}, mem_req_valid, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
    endtask

    task automatic run_dump(input logic [31:0] s, input logic [31:0] e,
                            input int rstall, input int ostall, input bit hold_start);
        int st_cyc;
        bit nonempty;
        model_load(s, e);
        nonempty = (exp_addr.size() != 0);
        req_stall = rstall;
        out_stall = ostall;
        done_cnt = 0; done_cyc = -1; last_hs_cyc = -1; req_cnt = 0;
        got_addr.delete(); got_data.delete(); got_last.delete();
        @(posedge clk); #1;
        start_addr = s;
        end_addr   = e;
        start      = 1'b1;
        @(negedge clk); #1;
        st_cyc = cyc;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        @(negedge clk); #1;
        if (nonempty) chk("start_to_req_latency", mem_req_valid, 1);
        else          chk("empty_done_latency", done, 1);
        start = 1'b0;
        for (int k = 0; k < 400 && done_cyc < 0; k++) begin
            @(negedge clk); #1;
        end
        chk("done_seen", done_cyc >= 0, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("done_pulse_count", done_cnt, 1);
        chk("req_count", req_cnt, exp_nblk);
        chk("words_left", exp_addr.size(), 0);
        chk("busy_after", busy, 0);
        if (nonempty) chk("done_after_last_hs", done_cyc, last_hs_cyc + 1);
        else          chk("done_at_n_plus_1", done_cyc, st_cyc + 1);
    endtask

    initial begin
        mem[32'h0001018c] = 32'h00050613;
        mem[32'h00010190] = 32'h02a05463;
        mem[32'h00010194] = 32'h00000793;

        rst_aL = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_out_addr", out_addr, 0);
        chk("reset_out_data", out_data, 0);
        @(posedge clk); #1;
        rst_aL = 1'b1;

        // Reference range: pin the model, then the DUT stream.
        model_load(32'h0001018c, 32'h00010198);
        chk("model_n_words", exp_addr.size(), 3);
        chk("model_blk0", exp_blk[0], 29'h2031);
        chk("model_blk1", exp_blk[1], 29'h2032);
        run_dump(32'h0001018c, 32'h00010198, 0, 0, 0);
        chk("lit_n", got_addr.size(), 3);
        if (got_addr.size() == 3) begin
            chk("lit_a0", got_addr[0], 32'h0001018c);
            chk("lit_d0", got_data[0], 32'h00050613);
            chk("lit_a1", got_addr[1], 32'h00010190);
            chk("lit_d1", got_data[1], 32'h02a05463);
            chk("lit_a2", got_addr[2], 32'h00010194);
            chk("lit_d2", got_data[2], 32'h00000793);
            chk("lit_last", {got_last[0], got_last[1], got_last[2]}, 3'b001);
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        chk("checksum_lit", checksum, 32'h02a56209);
`endif

        run_dump(32'h00000100, 32'h00000100, 0, 0, 0);
        run_dump(32'h0001018c, 32'h00010198, 0, 5, 0);
        run_dump(32'h00000300, 32'h00000320, 3, 0, 1);
        run_dump(32'h0001018e, 32'h0001019b, 0, 2, 0);
        run_dump(32'hFFFFFFF8, 32'h00000000, 0, 0, 0);
        run_dump(32'h00000104, 32'h00000100, 0, 0, 0);
        run_dump(32'h00000400, 32'h00000404, 0, 0, 0);
        run_dump(32'hFFFFFFF0, 32'hFFFFFFFC, 0, 0, 0);

        // Reset while waiting for the block, with the response landing after reset.
        model_load(32'h00000200, 32'h00000210);
        resp_lat = 2;
        chk_resp_lat = 1'b0;
        req_cnt = 0; done_cnt = 0;
        @(posedge clk); #1;
        start_addr = 32'h00000200;
        end_addr   = 32'h00000210;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20 && req_cnt == 0; k++) begin
            @(negedge clk); #1;
        end
        chk("rst_test_req_seen", req_cnt, 1);
        @(posedge clk); #1;
        rst_aL = 1'b0;
        @(posedge clk); #1;
        rst_aL = 1'b1;
        exp_addr.delete(); exp_data.delete(); exp_blk.delete();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_idle_outputs("post_reset");
        end
        chk("post_reset_done_count", done_cnt, 0);
        resp_lat = 1;
        chk_resp_lat = 1'b1;

        run_dump(32'h0001018c, 32'h00010198, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
